// File: rtl/gpr_pkg.sv
// Shared types and constants for the gpr_sb register file and its scoreboard.
package gpr_pkg;

  // Register-file lifecycle: zeroing sweep after reset, then normal operation
  typedef enum logic {
    GPR_INIT = 1'b0,
    GPR_RUN  = 1'b1
  } gpr_state_e;

  localparam int GPR_XLEN_DEFAULT = 32;
  localparam int GPR_NREG_DEFAULT = 32;

  // Index width for a file of nreg registers (never narrower than one bit)
  function automatic int gprIdxWidth(input int nreg);
    return (nreg > 2) ? $clog2(nreg) : 1;
  endfunction

endpackage

// File: rtl/gpr_scoreboard.sv
// Busy scoreboard for gpr_sb: one pending-writeback bit per register,
// issue acceptance, and the set-over-clear priority when issue and
// writeback hit the same register on the same edge.
module gpr_scoreboard
  import gpr_pkg::*;
#(
  parameter int NREG     = GPR_NREG_DEFAULT,
  parameter int AW       = gprIdxWidth(NREG),
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_run,
  input  logic            i_clrEn,
  input  logic [AW-1:0]   i_clrIdx,
  input  logic            i_issueEn,
  input  logic [AW-1:0]   i_issueIdx,
  output logic [NREG-1:0] o_busy,
  output logic            o_issueAck
);

  logic [NREG-1:0] r_busy;
  logic            w_rdInRange;
  logic            w_rdIsZero;
  logic            w_rdBusy;
  logic            w_setEn;

  assign w_rdInRange = (32'(i_issueIdx) < NREG);
  assign w_rdIsZero  = (ZERO_REG != 0) && (i_issueIdx == '0);
  assign w_rdBusy    = w_rdInRange ? r_busy[i_issueIdx] : 1'b1;

  // The ack looks only at registered busy, so a same-cycle writeback cannot unblock an issue
  assign o_issueAck = i_run && i_issueEn && w_rdInRange && (!w_rdBusy || w_rdIsZero);
  assign w_setEn    = o_issueAck && !w_rdIsZero;
  assign o_busy     = r_busy;

  // Writeback clears, an accepted issue sets; the set is written last so it wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      if (i_clrEn) begin
        r_busy[i_clrIdx] <= 1'b0;
      end
      if (w_setEn) begin
        r_busy[i_issueIdx] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpr_sb.sv
// gpr_sb: parametrised self-initialising register file with one write port,
// NRD combinational read ports and a per-register busy scoreboard.
// Optional macro GPR_BYPASS_EN forwards a same-cycle writeback to matching
// read ports; without it reads see the stored value and registered busy bit.
module gpr_sb
  import gpr_pkg::*;
#(
  parameter  int XLEN     = GPR_XLEN_DEFAULT,
  parameter  int NREG     = GPR_NREG_DEFAULT,
  parameter  int NRD      = 2,
  parameter  int ZERO_REG = 1,
  localparam int AW       = gprIdxWidth(NREG)
) (
  input  logic                i_WrClk,
  input  logic                i_rst,
  output logic                o_Ready,
  input  logic                i_RegWr,
  input  logic [AW-1:0]       i_Rw,
  input  logic [XLEN-1:0]     i_busW,
  input  logic                i_IssueEn,
  input  logic [AW-1:0]       i_Rd,
  output logic                o_IssueAck,
  input  logic [NRD*AW-1:0]   i_Ra,
  output logic [NRD*XLEN-1:0] o_busA,
  output logic [NRD-1:0]      o_RaBusy
);

  gpr_state_e      r_state;
  logic [AW-1:0]   r_ptr;
  logic            r_ready;
  logic [XLEN-1:0] r_gpr [NREG];

  logic [NREG-1:0] w_busy;
  logic            w_rwWritable;
  logic            w_wrEn;

  assign w_rwWritable = (32'(i_Rw) < NREG) && !((ZERO_REG != 0) && (i_Rw == '0));
  assign w_wrEn       = r_ready && i_RegWr && w_rwWritable;
  assign o_Ready      = r_ready;

  // Lifecycle FSM: sweep ptr across every register after reset, then go live
  always_ff @(posedge i_WrClk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= GPR_INIT;
      r_ptr   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        GPR_INIT: begin
          r_ptr <= r_ptr + 1'b1;
          if (r_ptr == AW'(NREG - 1)) begin
            r_state <= GPR_RUN;
            r_ready <= 1'b1;
          end
        end
        GPR_RUN: begin
          r_state <= GPR_RUN;
        end
        default: begin
          r_state <= GPR_INIT;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // Storage has no reset; the sweep zeroes it, after which writeback owns it
  always_ff @(posedge i_WrClk) begin
    if (r_state == GPR_INIT) begin
      r_gpr[r_ptr] <= '0;
    end else if (w_wrEn) begin
      r_gpr[i_Rw] <= i_busW;
    end
  end

  gpr_scoreboard #(
    .NREG     (NREG),
    .AW       (AW),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (i_WrClk),
    .rst_n      (i_rst),
    .i_run      (r_ready),
    .i_clrEn    (w_wrEn),
    .i_clrIdx   (i_Rw),
    .i_issueEn  (i_IssueEn),
    .i_issueIdx (i_Rd),
    .o_busy     (w_busy),
    .o_issueAck (o_IssueAck)
  );

  // Independent read ports; everything reads as zero until the sweep is done
  for (genvar p = 0; p < NRD; p++) begin : g_read
    logic [AW-1:0]   w_idx;
    logic            w_readable;
    logic [XLEN-1:0] w_stored;
    logic            w_storedBusy;

    assign w_idx        = i_Ra[p*AW +: AW];
    assign w_readable   = r_ready && (32'(w_idx) < NREG) &&
                          !((ZERO_REG != 0) && (w_idx == '0));
    assign w_stored     = w_readable ? r_gpr[w_idx] : '0;
    assign w_storedBusy = w_readable ? w_busy[w_idx] : 1'b0;

`ifdef GPR_BYPASS_EN
    logic w_fwd;
    assign w_fwd = w_wrEn && (i_Rw == w_idx);
    assign o_busA[p*XLEN +: XLEN] = w_fwd ? i_busW : w_stored;
    assign o_RaBusy[p]            = w_fwd ? 1'b0 : w_storedBusy;
`else
    assign o_busA[p*XLEN +: XLEN] = w_stored;
    assign o_RaBusy[p]            = w_storedBusy;
`endif
  end

endmodule

// File: tb/tb_gpr_sb.sv
// Self-checking bench for gpr_sb (NREG=32, NRD=2) against a behavioural
// model of the register contents, busy set and init countdown.
module tb_gpr_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                regWr = 1'b0;
  logic [AW-1:0]       rw = '0;
  logic [XLEN-1:0]     busW = '0;
  logic                issueEn = 1'b0;
  logic [AW-1:0]       rd = '0;
  logic [NRD*AW-1:0]   ra = '0;
  logic                ready;
  logic                issueAck;
  logic [NRD*XLEN-1:0] busA;
  logic [NRD-1:0]      raBusy;

  logic [31:0] modelGpr [NREG];
  bit          modelBusy [NREG];
  bit          modelReady;
  int          sweepEdges;
  bit          expAck;
  int          checkCount = 0;
  int          errorCount = 0;

  always #5 clk = ~clk;

  gpr_sb #(
    .XLEN     (XLEN),
    .NREG     (NREG),
    .NRD      (NRD),
    .ZERO_REG (1)
  ) dut (
    .i_WrClk    (clk),
    .i_rst      (rst),
    .o_Ready    (ready),
    .i_RegWr    (regWr),
    .i_Rw       (rw),
    .i_busW     (busW),
    .i_IssueEn  (issueEn),
    .i_Rd       (rd),
    .o_IssueAck (issueAck),
    .i_Ra       (ra),
    .o_busA     (busA),
    .o_RaBusy   (raBusy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic compareAll(input string tag);
    logic [AW-1:0] idx;
    logic [31:0]   eData;
    logic          eBusy;
    expAck = modelReady && issueEn && (rd == 0 || !modelBusy[rd]);
    checkOutput({tag, ".ready"}, 32'(ready), 32'(modelReady));
    checkOutput({tag, ".ack"}, 32'(issueAck), 32'(expAck));
    for (int p = 0; p < NRD; p++) begin
      idx   = ra[p*AW +: AW];
      eData = '0;
      eBusy = 1'b0;
      if (modelReady && idx != 0) begin
        eData = modelGpr[idx];
        eBusy = modelBusy[idx];
`ifdef GPR_BYPASS_EN
        if (regWr && rw == idx) begin
          eData = busW;
          eBusy = 1'b0;
        end
`endif
      end
      checkOutput($sformatf("%s.busA%0d", tag, p), busA[p*XLEN +: XLEN], eData);
      checkOutput($sformatf("%s.busy%0d", tag, p), 32'(raBusy[p]), 32'(eBusy));
    end
  endtask

  task automatic updateModel();
    if (!modelReady) begin
      sweepEdges++;
      if (sweepEdges == NREG) begin
        modelReady = 1'b1;
        for (int i = 0; i < NREG; i++) modelGpr[i] = '0;
      end
    end else begin
      if (regWr && rw != 0) begin
        modelGpr[rw]  = busW;
        modelBusy[rw] = 1'b0;
      end
      if (expAck && rd != 0) modelBusy[rd] = 1'b1;
    end
  endtask

  // Called just after a negedge; drives one cycle, checks, and returns at the next negedge
  task automatic applyStimulus(input logic wr, input logic [AW-1:0] rwV, input logic [31:0] wd,
                               input logic iss, input logic [AW-1:0] rdV,
                               input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                               input string tag);
    regWr   = wr;
    rw      = rwV;
    busW    = wd;
    issueEn = iss;
    rd      = rdV;
    ra      = {ra1, ra0};
    #2;
    compareAll(tag);
    @(posedge clk);
    updateModel();
    @(negedge clk);
  endtask

  task automatic resetDut(input string tag);
    #3 rst = 1'b0;
    modelReady = 1'b0;
    sweepEdges = 0;
    for (int i = 0; i < NREG; i++) modelBusy[i] = 1'b0;
    #1 compareAll(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic runSweep();
    for (int i = 0; i < NREG; i++) begin
      applyStimulus(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom),
                    5'($urandom), 5'($urandom), "sweep");
    end
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) begin
      modelGpr[i]  = '0;
      modelBusy[i] = 1'b0;
    end
    modelReady = 1'b0;
    sweepEdges = 0;

    @(negedge clk);
    resetDut("por");
    runSweep();

    for (int i = 1; i < NREG; i++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'(i), 5'(NREG - i), "zeroAfterInit");
    end

    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd0, "wr5");
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5, "rd5");
    applyStimulus(1'b1, 5'd0, 32'hCAFEF00D, 1'b0, 5'd0, 5'd0, 5'd0, "wrX0");
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd5, "rdX0");

    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd0, "issue7");
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd7, "reissue7");
    applyStimulus(1'b1, 5'd7, 32'h00000777, 1'b1, 5'd7, 5'd7, 5'd0, "wb7");
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd0, "issue7again");
    applyStimulus(1'b1, 5'd7, 32'h00000778, 1'b0, 5'd0, 5'd7, 5'd7, "wb7b");

    applyStimulus(1'b1, 5'd9, 32'h99999999, 1'b1, 5'd9, 5'd9, 5'd0, "wrIssue9");
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9, "rd9");

    applyStimulus(1'b1, 5'd3, 32'hAAAA0003, 1'b0, 5'd0, 5'd0, 5'd0, "pre3");
    applyStimulus(1'b1, 5'd3, 32'h12345678, 1'b0, 5'd0, 5'd0, 5'd3, "fwd3");
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3, "rd3");

    applyStimulus(1'b1, 5'd4, 32'h44444444, 1'b1, 5'd4, 5'd0, 5'd0, "issue4");
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd4, "busy4");
    issueEn = 1'b1;
    rd      = 5'd10;
    ra      = {5'd4, 5'd4};
    resetDut("midReset");
    runSweep();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd4, "rd4AfterReset");

    for (int n = 0; n < 400; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 5'($urandom), $urandom,
                    1'($urandom_range(0, 1)), 5'($urandom),
                    5'($urandom), 5'($urandom), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
